// File: rtl/sd_cmd_arbiter_if.sv
// rtl/sd_cmd_arbiter_if.sv - requester and engine bundle of the SD command arbiter
interface sd_cmd_arbiter_if #(
   parameter int N_REQ = 3
);
   // requester side
   logic [N_REQ-1:0]    req_valid;
   logic [6*N_REQ-1:0]  req_cmd_id;
   logic [32*N_REQ-1:0] req_arg;
   logic [N_REQ-1:0]    req_resp_exp;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    rsp_done;
   logic [N_REQ-1:0]    rsp_tmo;
   logic [47:0]         rsp_r1_r3;
   logic [135:0]        rsp_r2;
   // engine side
   logic [5:0]          CMD_ID;
   logic [7:0]          Arg1;
   logic [7:0]          Arg2;
   logic [7:0]          Arg3;
   logic [7:0]          Arg4;
   logic                Send_CMD_En;
   logic                Get_CMD_En;
   logic                Send_CMD_Complite;
   logic                Get_CMD_Complite;
   logic [47:0]         Responce_R1_R3;
   logic [135:0]        Responce_R2;

   // master: the arbiter itself
   modport master (
      input  req_valid, req_cmd_id, req_arg, req_resp_exp,
      output gnt, rsp_done, rsp_tmo, rsp_r1_r3, rsp_r2,
      output CMD_ID, Arg1, Arg2, Arg3, Arg4, Send_CMD_En, Get_CMD_En,
      input  Send_CMD_Complite, Get_CMD_Complite, Responce_R1_R3, Responce_R2
   );

   // slave: requesters plus command engine
   modport slave (
      output req_valid, req_cmd_id, req_arg, req_resp_exp,
      input  gnt, rsp_done, rsp_tmo, rsp_r1_r3, rsp_r2,
      input  CMD_ID, Arg1, Arg2, Arg3, Arg4, Send_CMD_En, Get_CMD_En,
      output Send_CMD_Complite, Get_CMD_Complite, Responce_R1_R3, Responce_R2
   );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// rtl/sd_cmd_arbiter.sv - shares one SD command engine among N_REQ requesters
module sd_cmd_arbiter #(
   parameter int N_REQ       = 3,
   parameter int ARB_RR      = 0,
   parameter int TIMEOUT_CYC = 255
) (
   input logic              clk_400k,
   input logic              rst_n,
   sd_cmd_arbiter_if.master io_cmd
);
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_GET, S_DONE, S_DRAIN} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t           r_state, w_state;
   logic [N_REQ-1:0] r_gnt, w_gnt;
   logic [N_REQ-1:0] r_done, w_done;
   logic [N_REQ-1:0] r_tmo, w_tmo;
   logic             r_resp_exp, w_resp_exp;
   logic [5:0]       r_cmd_id, w_cmd_id;
   logic [31:0]      r_arg, w_arg;
   logic             r_send_en, w_send_en;
   logic             r_get_en, w_get_en;
   logic [7:0]       r_cnt, w_cnt;
   logic [47:0]      r_r1, w_r1;
   logic [135:0]     r_r2, w_r2;
   logic [2:0]       r_rr_ptr, w_rr_ptr;

   logic             w_found;
   logic [N_REQ-1:0] w_win_oh;
   int               w_win_idx;
   int               w_best;
   int               w_dist;
   logic [5:0]       w_win_cmd;
   logic [31:0]      w_win_arg;
   logic             w_win_rexp;

   // Winner pick: smallest distance from the search start (index 0, or rr pointer)
   always_comb begin
      w_found    = |io_cmd.req_valid;
      w_win_oh   = '0;
      w_win_idx  = 0;
      w_best     = N_REQ;
      w_dist     = 0;
      w_win_cmd  = '0;
      w_win_arg  = '0;
      w_win_rexp = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         w_dist = (ARB_RR != 0) ? (j - int'(r_rr_ptr) + N_REQ) % N_REQ : j;
         if (io_cmd.req_valid[j] && (w_dist < w_best)) begin
            w_best    = w_dist;
            w_win_idx = j;
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (w_found && (w_win_idx == j)) begin
            w_win_oh[j] = 1'b1;
            w_win_cmd   = io_cmd.req_cmd_id[6*j +: 6];
            w_win_arg   = io_cmd.req_arg[32*j +: 32];
            w_win_rexp  = io_cmd.req_resp_exp[j];
         end
      end
   end

   // Next-state and next-output logic of the command sequencer
   always_comb begin
      w_state    = r_state;
      w_gnt      = r_gnt;
      w_done     = '0;
      w_tmo      = '0;
      w_resp_exp = r_resp_exp;
      w_cmd_id   = r_cmd_id;
      w_arg      = r_arg;
      w_send_en  = r_send_en;
      w_get_en   = r_get_en;
      w_cnt      = r_cnt;
      w_r1       = r_r1;
      w_r2       = r_r2;
      w_rr_ptr   = r_rr_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state    = S_SEND;
               w_gnt      = w_win_oh;
               w_cmd_id   = w_win_cmd;
               w_arg      = w_win_arg;
               w_resp_exp = w_win_rexp;
               w_send_en  = 1'b1;
               w_cnt      = '0;
               w_rr_ptr   = 3'((w_win_idx + 1) % N_REQ);
            end
         end
         S_SEND: begin
            // a complete on the last counted cycle still wins over the timeout
            if (io_cmd.Send_CMD_Complite) begin
               w_send_en = 1'b0;
               w_cnt     = '0;
               if (r_resp_exp) begin
                  w_get_en = 1'b1;
                  w_state  = S_GET;
               end else begin
                  w_done  = r_gnt;
                  w_state = S_DONE;
               end
            end else if (r_cnt == TMO_LAST) begin
               w_send_en = 1'b0;
               w_get_en  = 1'b0;
               w_tmo     = r_gnt;
               w_state   = S_DRAIN;
            end else begin
               w_cnt = r_cnt + 8'd1;
            end
         end
         S_GET: begin
            if (io_cmd.Get_CMD_Complite) begin
               w_get_en = 1'b0;
               w_r1     = io_cmd.Responce_R1_R3;
               w_r2     = io_cmd.Responce_R2;
               w_done   = r_gnt;
               w_state  = S_DONE;
            end else if (r_cnt == TMO_LAST) begin
               w_send_en = 1'b0;
               w_get_en  = 1'b0;
               w_tmo     = r_gnt;
               w_state   = S_DRAIN;
            end else begin
               w_cnt = r_cnt + 8'd1;
            end
         end
         S_DONE: begin
            w_state = S_DRAIN;
         end
         S_DRAIN: begin
            // keep the owner until the engine has dropped both completes
            if (!io_cmd.Send_CMD_Complite && !io_cmd.Get_CMD_Complite) begin
               w_gnt   = '0;
               w_state = S_IDLE;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk_400k) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_done     <= '0;
         r_tmo      <= '0;
         r_resp_exp <= 1'b0;
         r_cmd_id   <= '0;
         r_arg      <= '0;
         r_send_en  <= 1'b0;
         r_get_en   <= 1'b0;
         r_cnt      <= '0;
         r_r1       <= '0;
         r_r2       <= '0;
         r_rr_ptr   <= '0;
      end else begin
         r_state    <= w_state;
         r_gnt      <= w_gnt;
         r_done     <= w_done;
         r_tmo      <= w_tmo;
         r_resp_exp <= w_resp_exp;
         r_cmd_id   <= w_cmd_id;
         r_arg      <= w_arg;
         r_send_en  <= w_send_en;
         r_get_en   <= w_get_en;
         r_cnt      <= w_cnt;
         r_r1       <= w_r1;
         r_r2       <= w_r2;
         r_rr_ptr   <= w_rr_ptr;
      end
   end

   assign io_cmd.gnt         = r_gnt;
   assign io_cmd.rsp_done    = r_done;
   assign io_cmd.rsp_tmo     = r_tmo;
   assign io_cmd.rsp_r1_r3   = r_r1;
   assign io_cmd.rsp_r2      = r_r2;
   assign io_cmd.CMD_ID      = r_cmd_id;
   assign io_cmd.Arg1        = r_arg[31:24];
   assign io_cmd.Arg2        = r_arg[23:16];
   assign io_cmd.Arg3        = r_arg[15:8];
   assign io_cmd.Arg4        = r_arg[7:0];
   assign io_cmd.Send_CMD_En = r_send_en;
   assign io_cmd.Get_CMD_En  = r_get_en;
endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb/tb_sd_cmd_arbiter.sv - directed bench for sd_cmd_arbiter
module tb_sd_cmd_arbiter;
   logic clk_400k = 1'b0;
   logic rst_n    = 1'b0;
   int   checks   = 0;
   int   errors   = 0;

   always #5 clk_400k = ~clk_400k;

   sd_cmd_arbiter_if #(.N_REQ(3)) if0 ();
   sd_cmd_arbiter_if #(.N_REQ(3)) if1 ();

   sd_cmd_arbiter #(.N_REQ(3), .ARB_RR(0), .TIMEOUT_CYC(255)) u_dut0 (
      .clk_400k (clk_400k),
      .rst_n    (rst_n),
      .io_cmd   (if0)
   );

   sd_cmd_arbiter #(.N_REQ(3), .ARB_RR(1), .TIMEOUT_CYC(255)) u_dut1 (
      .clk_400k (clk_400k),
      .rst_n    (rst_n),
      .io_cmd   (if1)
   );

   // engine model for the round-robin instance: finishes every send in one cycle
   assign if1.Send_CMD_Complite = if1.Send_CMD_En;
   assign if1.Get_CMD_Complite  = 1'b0;
   assign if1.Responce_R1_R3    = '0;
   assign if1.Responce_R2       = '0;
   assign if1.req_cmd_id        = '0;
   assign if1.req_arg           = '0;
   assign if1.req_resp_exp      = '0;

   localparam logic [47:0]  R1_A = 48'h3F00_0001_AA5B;
   localparam logic [135:0] R2_A = {8'h3F, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
   localparam logic [47:0]  R1_B = 48'hAAAA_BBBB_CCCC;

   task automatic tick();
      @(posedge clk_400k);
      #1;
   endtask

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   logic [2:0] seq [6];
   logic [2:0] prev;
   int         n_seen;
   int         cyc;

   initial begin
      if0.req_valid         = '0;
      if0.req_cmd_id        = '0;
      if0.req_arg           = '0;
      if0.req_resp_exp      = '0;
      if0.Send_CMD_Complite = 1'b0;
      if0.Get_CMD_Complite  = 1'b0;
      if0.Responce_R1_R3    = '0;
      if0.Responce_R2       = '0;
      if1.req_valid         = '0;
      for (int k = 0; k < 6; k++) seq[k] = '0;

      // reset state
      tick();
      tick();
      chk("rst_gnt", if0.gnt, 3'b000);
      chk("rst_send_en", if0.Send_CMD_En, 1'b0);
      chk("rst_cmd_id", if0.CMD_ID, 6'd0);
      chk("rst_r1", if0.rsp_r1_r3, 48'd0);
      chk("rst_done", if0.rsp_done, 3'b000);
      rst_n = 1'b1;
      tick();
      chk("idle_gnt", if0.gnt, 3'b000);

      // 1: CMD8 with response from requester 0
      if0.req_cmd_id[5:0]   = 6'd8;
      if0.req_arg[31:0]     = 32'h0000_01AA;
      if0.req_resp_exp[0]   = 1'b1;
      if0.req_valid         = 3'b001;
      tick();
      chk("t1_gnt", if0.gnt, 3'b001);
      chk("t1_send_en", if0.Send_CMD_En, 1'b1);
      chk("t1_cmd_id", if0.CMD_ID, 6'd8);
      chk("t1_arg1", if0.Arg1, 8'h00);
      chk("t1_arg3", if0.Arg3, 8'h01);
      chk("t1_arg4", if0.Arg4, 8'hAA);
      tick();
      tick();
      chk("t1_send_hold", if0.Send_CMD_En, 1'b1);
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      chk("t1_send_drop", if0.Send_CMD_En, 1'b0);
      chk("t1_get_en", if0.Get_CMD_En, 1'b1);
      if0.Responce_R1_R3   = R1_A;
      if0.Responce_R2      = R2_A;
      if0.Get_CMD_Complite = 1'b1;
      tick();
      if0.Get_CMD_Complite = 1'b0;
      if0.req_valid        = 3'b000;
      chk("t1_get_drop", if0.Get_CMD_En, 1'b0);
      chk("t1_done", if0.rsp_done, 3'b001);
      chk("t1_r1", if0.rsp_r1_r3, R1_A);
      chk("t1_r2", if0.rsp_r2, R2_A);
      tick();
      chk("t1_done_pulse", if0.rsp_done, 3'b000);
      chk("t1_drain_gnt", if0.gnt, 3'b001);
      tick();
      chk("t1_idle_gnt", if0.gnt, 3'b000);

      // 2: CMD0 without response
      if0.req_cmd_id[5:0] = 6'd0;
      if0.req_arg[31:0]   = 32'h0;
      if0.req_resp_exp    = 3'b000;
      if0.req_valid       = 3'b001;
      tick();
      chk("t2_gnt", if0.gnt, 3'b001);
      chk("t2_send_en", if0.Send_CMD_En, 1'b1);
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      if0.req_valid         = 3'b000;
      chk("t2_get_en", if0.Get_CMD_En, 1'b0);
      chk("t2_done", if0.rsp_done, 3'b001);
      chk("t2_r1_hold", if0.rsp_r1_r3, R1_A);
      tick();
      chk("t2_get_en_late", if0.Get_CMD_En, 1'b0);
      tick();
      chk("t2_idle_gnt", if0.gnt, 3'b000);

      // 3: req0 and req2 together under fixed priority
      if0.req_cmd_id[5:0]   = 6'd17;
      if0.req_cmd_id[17:12] = 6'd24;
      if0.req_valid         = 3'b101;
      tick();
      chk("t3_gnt_first", if0.gnt, 3'b001);
      chk("t3_cmd_first", if0.CMD_ID, 6'd17);
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      chk("t3_done0", if0.rsp_done, 3'b001);
      if0.req_valid = 3'b100;
      tick();
      chk("t3_drain_gnt", if0.gnt, 3'b001);
      tick();
      chk("t3_gap_gnt", if0.gnt, 3'b000);
      tick();
      chk("t3_gnt_second", if0.gnt, 3'b100);
      chk("t3_cmd_second", if0.CMD_ID, 6'd24);
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      if0.req_valid         = 3'b000;
      chk("t3_done2", if0.rsp_done, 3'b100);
      tick();
      tick();
      chk("t3_idle_gnt", if0.gnt, 3'b000);

      // 5: response timeout on requester 1
      if0.req_cmd_id[11:6] = 6'd17;
      if0.req_resp_exp     = 3'b010;
      if0.req_valid        = 3'b010;
      tick();
      chk("t5_gnt", if0.gnt, 3'b010);
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      if0.Responce_R1_R3    = R1_B;
      chk("t5_get_en", if0.Get_CMD_En, 1'b1);
      n_seen = 0;
      while (if0.rsp_tmo == 3'b000 && n_seen < 400) begin
         tick();
         n_seen++;
      end
      if0.req_valid = 3'b000;
      chk("t5_tmo_cycles", n_seen, 255);
      chk("t5_tmo", if0.rsp_tmo, 3'b010);
      chk("t5_no_done", if0.rsp_done, 3'b000);
      chk("t5_get_drop", if0.Get_CMD_En, 1'b0);
      chk("t5_r1_hold", if0.rsp_r1_r3, R1_A);
      tick();
      chk("t5_tmo_pulse", if0.rsp_tmo, 3'b000);
      chk("t5_idle_gnt", if0.gnt, 3'b000);

      // 6: reset while waiting in GET
      if0.req_cmd_id[5:0] = 6'd55;
      if0.req_resp_exp    = 3'b001;
      if0.req_valid       = 3'b001;
      tick();
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      chk("t6_get_en", if0.Get_CMD_En, 1'b1);
      tick();
      rst_n = 1'b0;
      tick();
      chk("t6_rst_gnt", if0.gnt, 3'b000);
      chk("t6_rst_get_en", if0.Get_CMD_En, 1'b0);
      chk("t6_rst_cmd_id", if0.CMD_ID, 6'd0);
      chk("t6_rst_r1", if0.rsp_r1_r3, 48'd0);
      chk("t6_rst_r2", if0.rsp_r2, 136'd0);
      chk("t6_rst_done", if0.rsp_done, 3'b000);
      chk("t6_rst_tmo", if0.rsp_tmo, 3'b000);
      rst_n               = 1'b1;
      if0.req_cmd_id[5:0] = 6'd13;
      if0.req_resp_exp    = 3'b000;
      tick();
      chk("t6_new_gnt", if0.gnt, 3'b001);
      chk("t6_new_cmd", if0.CMD_ID, 6'd13);
      chk("t6_new_send_en", if0.Send_CMD_En, 1'b1);
      if0.Send_CMD_Complite = 1'b1;
      tick();
      if0.Send_CMD_Complite = 1'b0;
      if0.req_valid         = 3'b000;
      chk("t6_new_done", if0.rsp_done, 3'b001);
      tick();
      tick();

      // 4: round-robin with all three requesting continuously
      if1.req_valid = 3'b111;
      prev   = if1.gnt;
      n_seen = 0;
      cyc    = 0;
      while (n_seen < 6 && cyc < 200) begin
         tick();
         cyc++;
         if (prev == 3'b000 && if1.gnt != 3'b000) begin
            seq[n_seen] = if1.gnt;
            n_seen++;
         end
         prev = if1.gnt;
      end
      if1.req_valid = 3'b000;
      chk("t4_grant_count", n_seen, 6);
      chk("t4_order0", seq[0], 3'b001);
      chk("t4_order1", seq[1], 3'b010);
      chk("t4_order2", seq[2], 3'b100);
      chk("t4_order3", seq[3], 3'b001);
      chk("t4_order4", seq[4], 3'b010);
      chk("t4_order5", seq[5], 3'b100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
